// File: rtl/hp_pkg.sv
// Shared definitions for the player hit-point tracker: FSM state encoding
// and default parameter values.
package hp_pkg;

  localparam int HP_MAX_DEF       = 5;
  localparam int HP_W_DEF         = 3;
  localparam int FLASH_CYCLES_DEF = 2000000;

  typedef logic [1:0] state_t;

  localparam state_t ST_ALIVE = 2'd0;
  localparam state_t ST_HURT  = 2'd1;
  localparam state_t ST_DEAD  = 2'd2;

endpackage

// File: rtl/hp_tracker_rise_detect.sv
// Rising-edge detector for the collision level: one register stage and a
// combinational rise flag that is high in the cycle the level first reads 1.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic in_q_r;

  // Delay the input by one cycle so its previous value is available.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q_r <= 1'b0;
    end else begin
      in_q_r <= in;
    end
  end

  assign rise = in & ~in_q_r;

endmodule

// File: rtl/hp_tracker.sv
// Player hit-point tracker. Damage is taken on each new collision, followed
// by a blinking invulnerability window that lasts while the collision level
// stays high. Reaching zero HP locks the tracker until restart.
// Optional feature: define HP_HEAL_EN to let the heal pulse add one HP
// (saturating at HP_MAX); otherwise heal is ignored.
module hp_tracker
  import hp_pkg::*;
#(
  parameter int HP_MAX       = HP_MAX_DEF,
  parameter int HP_W         = HP_W_DEF,
  parameter int FLASH_CYCLES = FLASH_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            collision,
  input  logic            restart,
  input  logic            heal,
  output logic [HP_W-1:0] hp,
  output logic            hit,
  output logic            dead,
  output logic            blink
);

  localparam int CNT_W = (FLASH_CYCLES > 2) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [HP_W-1:0]  HP_FULL  = HP_W'(HP_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_CYCLES - 1);

  state_t           state_r, state_s;
  logic [HP_W-1:0]  hp_r, hp_s;
  logic             hit_r, hit_s;
  logic             dead_r, dead_s;
  logic             blink_r, blink_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             rise_s;

`ifdef HP_HEAL_EN
  // One HP up, never past the full value.
  function automatic logic [HP_W-1:0] hp_inc(input logic [HP_W-1:0] v);
    return (v >= HP_FULL) ? v : v + HP_W'(1);
  endfunction
`else
  // The heal port stays on the boundary but drives nothing.
  logic unused_heal_s;
  assign unused_heal_s = heal;
`endif

  rise_detect u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (collision),
    .rise (rise_s)
  );

  // Next-state and next-output computation for the ALIVE/HURT/DEAD machine.
  always_comb begin
    state_s = state_r;
    hp_s    = hp_r;
    hit_s   = 1'b0;
    dead_s  = dead_r;
    blink_s = blink_r;
    cnt_s   = cnt_r;
    if (restart) begin
      state_s = ST_ALIVE;
      hp_s    = HP_FULL;
      dead_s  = 1'b0;
      blink_s = 1'b1;
      cnt_s   = '0;
    end else begin
      case (state_r)
        ST_ALIVE: begin
          if (rise_s) begin
            // Damage wins over a coincident heal.
            hit_s   = 1'b1;
            blink_s = 1'b0;
            cnt_s   = '0;
            if (hp_r > HP_W'(1)) begin
              hp_s    = hp_r - HP_W'(1);
              state_s = ST_HURT;
            end else begin
              hp_s    = '0;
              dead_s  = 1'b1;
              state_s = ST_DEAD;
            end
          end else begin
            blink_s = 1'b1;
            cnt_s   = '0;
`ifdef HP_HEAL_EN
            if (heal) begin
              hp_s = hp_inc(hp_r);
            end else begin
              hp_s = hp_r;
            end
`endif
          end
        end
        ST_HURT: begin
`ifdef HP_HEAL_EN
          if (heal) begin
            hp_s = hp_inc(hp_r);
          end else begin
            hp_s = hp_r;
          end
`endif
          if (!collision) begin
            state_s = ST_ALIVE;
            blink_s = 1'b1;
            cnt_s   = '0;
          end else if (cnt_r == CNT_LAST) begin
            cnt_s   = '0;
            blink_s = ~blink_r;
          end else begin
            cnt_s   = cnt_r + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          hp_s    = '0;
          dead_s  = 1'b1;
          blink_s = 1'b0;
          cnt_s   = '0;
        end
        default: begin
          state_s = ST_ALIVE;
          hp_s    = HP_FULL;
          dead_s  = 1'b0;
          blink_s = 1'b1;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // State and output registers, forced to the full-HP alive state on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_ALIVE;
      hp_r    <= HP_FULL;
      hit_r   <= 1'b0;
      dead_r  <= 1'b0;
      blink_r <= 1'b1;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      hp_r    <= hp_s;
      hit_r   <= hit_s;
      dead_r  <= dead_s;
      blink_r <= blink_s;
      cnt_r   <= cnt_s;
    end
  end

  assign hp    = hp_r;
  assign hit   = hit_r;
  assign dead  = dead_r;
  assign blink = blink_r;

endmodule

// File: tb/tb_hp_tracker.sv
// Directed testbench for hp_tracker with HP_MAX=3, FLASH_CYCLES=4.
// Heal expectations follow HP_HEAL_EN the same way the design does.
module tb_hp_tracker;

  logic       clk;
  logic       rst_n;
  logic       collision;
  logic       restart;
  logic       heal;
  logic [2:0] hp;
  logic       hit;
  logic       dead;
  logic       blink;

  int n_checks = 0;
  int n_errors = 0;

  hp_tracker #(.HP_MAX(3), .HP_W(3), .FLASH_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .collision(collision),
    .restart  (restart),
    .heal     (heal),
    .hp       (hp),
    .hit      (hit),
    .dead     (dead),
    .blink    (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int e_hp, input int e_hit,
                           input int e_dead, input int e_blink);
    check_eq({tag, ".hp"},    32'(hp),    32'(e_hp));
    check_eq({tag, ".hit"},   32'(hit),   32'(e_hit));
    check_eq({tag, ".dead"},  32'(dead),  32'(e_dead));
    check_eq({tag, ".blink"}, 32'(blink), 32'(e_blink));
  endtask

  initial begin
    int exp_blink;
    int hp_before;
    rst_n = 1'b0; collision = 1'b0; restart = 1'b0; heal = 1'b0;
    #12;
    check_all("reset", 3, 0, 0, 1);
    rst_n = 1'b1;
    tick();
    check_all("idle", 3, 0, 0, 1);

    // Long collision: one hit, blink toggles every 4 cycles.
    collision = 1'b1;
    tick();
    check_all("hold_e1", 2, 1, 0, 0);
    for (int i = 2; i <= 10; i++) begin
      tick();
      exp_blink = ((i - 1) / 4) % 2;
      check_all($sformatf("hold_e%0d", i), 2, 0, 0, exp_blink);
    end
    collision = 1'b0;
    tick();
    check_all("hold_release", 2, 0, 0, 1);
    tick();
    check_all("hold_alive", 2, 0, 0, 1);

    // Separated pulses down to zero.
    collision = 1'b1; tick();
    check_all("pulse1", 1, 1, 0, 0);
    collision = 1'b0; tick();
    check_all("pulse1_off", 1, 0, 0, 1);
    collision = 1'b1; tick();
    check_all("pulse2", 0, 1, 1, 0);
    collision = 1'b0; tick();
    check_all("pulse2_off", 0, 0, 1, 0);
    collision = 1'b1; heal = 1'b1; tick();
    check_all("dead_ignore", 0, 0, 1, 0);
    collision = 1'b0; tick();
    check_all("dead_ignore2", 0, 0, 1, 0);
    heal = 1'b0;

    // Restart out of DEAD, then normal damage.
    restart = 1'b1; tick();
    check_all("restart", 3, 0, 0, 1);
    restart = 1'b0;
    collision = 1'b1; tick();
    check_all("after_restart", 2, 1, 0, 0);
    collision = 1'b0; tick();
    check_all("after_restart_off", 2, 0, 0, 1);

    // Heal from hp=2.
    heal = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
`ifdef HP_HEAL_EN
      check_all($sformatf("heal%0d", i), 3, 0, 0, 1);
`else
      check_all($sformatf("heal%0d", i), 2, 0, 0, 1);
`endif
    end
    hp_before = int'(hp);
    collision = 1'b1; tick();
`ifdef HP_HEAL_EN
    check_all("heal_vs_rise", 2, 1, 0, 0);
`else
    check_all("heal_vs_rise", 1, 1, 0, 0);
`endif
    check_eq("heal_vs_rise.drop", 32'(hp), 32'(hp_before - 1));
    heal = 1'b0; collision = 1'b0; tick();
    check_eq("heal_vs_rise.alive", 32'(blink), 32'd1);

    // Reset in the middle of HURT with collision held.
    restart = 1'b1; tick();
    restart = 1'b0;
    check_eq("pre_hurt.hp", 32'(hp), 32'd3);
    collision = 1'b1; tick();
    check_all("hurt_entry", 2, 1, 0, 0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check_all("mid_hurt_reset", 3, 0, 0, 1);
    #3;
    rst_n = 1'b1;
    tick();
    check_all("rise_after_reset", 2, 1, 0, 0);
    tick();
    check_all("no_double_hit", 2, 0, 0, 0);
    collision = 1'b0; tick();
    check_all("final_alive", 2, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
